// File: rtl/bus_pkg.sv
// Shared definitions for the instruction/data bus arbiter: bus widths and
// the arbiter state encoding.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// External memory bus seen by the arbiter: the arbiter is the master,
// the memory or interconnect is the slave.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic              ext_valid;
  logic              ext_instruction;
  logic [ADDR_W-1:0] ext_address;
  logic [DATA_W-1:0] ext_write_data;
  logic [STRB_W-1:0] ext_write_strobe;
  logic              ext_ready;
  logic [DATA_W-1:0] ext_read_data;

  modport master (
    output ext_valid,
    output ext_instruction,
    output ext_address,
    output ext_write_data,
    output ext_write_strobe,
    input  ext_ready,
    input  ext_read_data
  );

  modport slave (
    input  ext_valid,
    input  ext_instruction,
    input  ext_address,
    input  ext_write_data,
    input  ext_write_strobe,
    output ext_ready,
    output ext_read_data
  );

endinterface

// File: rtl/bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single external bus. Data wins ties
// unless fetch has been passed over STARVE_LIMIT times in a row.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_kill,
  output logic              f_ready,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  bus_arbiter_if.master     ext,
  output logic              busy
);

  localparam int CNT_W = 4;

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             drop;
  logic             starve_hit;
  logic             grant_data;
  logic             grant_fetch;
  logic             xfer_done;

  assign starve_hit  = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_data  = d_req && !(starve_hit && f_req);
  assign grant_fetch = f_req && !grant_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= ST_IDLE;
      starve_cnt           <= '0;
      drop                 <= 1'b0;
      ext.ext_valid        <= 1'b0;
      ext.ext_instruction  <= 1'b0;
      ext.ext_address      <= '0;
      ext.ext_write_data   <= '0;
      ext.ext_write_strobe <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (grant_data) begin
            state                <= ST_DATA;
            ext.ext_valid        <= 1'b1;
            ext.ext_instruction  <= 1'b0;
            ext.ext_address      <= d_addr;
            ext.ext_write_data   <= d_wdata;
            ext.ext_write_strobe <= d_wstrb;
            // Only a data grant that overtakes a waiting fetch counts toward starvation
            if (!f_req) begin
              starve_cnt <= '0;
            end else if (!starve_hit) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_fetch) begin
            state                <= ST_FETCH;
            ext.ext_valid        <= 1'b1;
            ext.ext_instruction  <= 1'b1;
            ext.ext_address      <= f_addr;
            ext.ext_write_data   <= '0;
            ext.ext_write_strobe <= '0;
            starve_cnt           <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        ST_FETCH, ST_DATA: begin
          if (state == ST_FETCH && f_kill) begin
            drop <= 1'b1;
          end
          if (ext.ext_ready) begin
            state         <= ST_IDLE;
            ext.ext_valid <= 1'b0;
            drop          <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          ext.ext_valid <= 1'b0;
        end
      endcase
    end
  end

  // A kill arriving in the completion cycle itself must also swallow the response
  assign xfer_done = reset && ext.ext_ready;
  assign f_ready   = (state == ST_FETCH) && xfer_done && !drop && !f_kill;
  assign d_ready   = (state == ST_DATA) && xfer_done;
  assign f_rdata   = ext.ext_read_data;
  assign d_rdata   = ext.ext_read_data;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed requests push expected grants and
// responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_bus_arbiter;
  import bus_pkg::*;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } grant_t;

  typedef struct packed {
    logic        is_fetch;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_kill, f_ready;
  logic [31:0] f_addr, f_rdata;
  logic        d_req, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        busy;

  bus_arbiter_if bus_if ();

  bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_kill  (f_kill),
    .f_ready (f_ready),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_ready (d_ready),
    .d_rdata (d_rdata),
    .ext     (bus_if),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  grant_t grant_q[$];
  resp_t  resp_q[$];
  int     resp_wait = 1;
  bit     hold_ready = 1'b0;
  int     vcount = 0;
  int     valid_cycles = 0;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (~a ^ 32'h5A5A_0000);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic expectGrant(input logic instr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    grant_t g;
    g.instr = instr; g.addr = addr; g.wdata = wdata; g.strb = strb;
    grant_q.push_back(g);
  endtask

  task automatic expectResp(input logic is_fetch, input logic [31:0] data);
    resp_t r;
    r.is_fetch = is_fetch; r.data = data;
    resp_q.push_back(r);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the request until its ready pulse, then releases it one edge later
  task automatic applyStimulus(input bit is_fetch, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    bit    seen;
    string nm;
    nm = is_fetch ? "fetch_done" : "data_done";
    if (is_fetch) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = is_fetch ? f_ready : d_ready;
    end
    checkOutput(nm, seen, 1);
    @(posedge clk);
    #1;
    if (is_fetch) f_req = 1'b0;
    else d_req = 1'b0;
  endtask

  // Memory model: ready on the resp_wait-th valid cycle, or always when hold_ready
  initial begin
    bus_if.ext_ready     = 1'b0;
    bus_if.ext_read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.ext_valid) vcount++;
      else vcount = 0;
      bus_if.ext_ready     = hold_ready || (bus_if.ext_valid && vcount == resp_wait);
      bus_if.ext_read_data = memModel(bus_if.ext_address);
    end
  end

  logic   prev_valid = 1'b0;
  grant_t cur;
  grant_t g_pop;
  resp_t  r_pop;

  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (f_ready || d_ready) begin
        checkOutput("ready_exclusive", f_ready && d_ready, 0);
        checkOutput("ready_while_busy", busy, 1);
        checkOutput("resp_pending", resp_q.size() != 0, 1);
        if (resp_q.size() != 0) begin
          r_pop = resp_q.pop_front();
          checkOutput("resp_port", f_ready, r_pop.is_fetch);
          checkOutput("resp_data", f_ready ? f_rdata : d_rdata, r_pop.data);
        end
      end
      if (bus_if.ext_valid) begin
        valid_cycles++;
        checkOutput("busy_with_valid", busy, 1);
        if (!prev_valid) begin
          checkOutput("grant_pending", grant_q.size() != 0, 1);
          if (grant_q.size() != 0) cur = grant_q.pop_front();
        end
        checkOutput("ext_instruction", bus_if.ext_instruction, cur.instr);
        checkOutput("ext_address", bus_if.ext_address, cur.addr);
        checkOutput("ext_write_data", bus_if.ext_write_data, cur.wdata);
        checkOutput("ext_write_strobe", bus_if.ext_write_strobe, cur.strb);
      end
      prev_valid = bus_if.ext_valid;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int vc_start;

  initial begin
    reset = 1'b0;
    f_req = 1'b0; f_addr = '0; f_kill = 1'b0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    idleCycles(2);
    checkOutput("rst_ext_valid", bus_if.ext_valid, 0);
    checkOutput("rst_ext_instruction", bus_if.ext_instruction, 0);
    checkOutput("rst_ext_address", bus_if.ext_address, 0);
    checkOutput("rst_ext_write_data", bus_if.ext_write_data, 0);
    checkOutput("rst_ext_write_strobe", bus_if.ext_write_strobe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_f_ready", f_ready, 0);
    checkOutput("rst_d_ready", d_ready, 0);
    reset = 1'b1;
    idleCycles(2);

    $display("[TB] single fetch, with a data request withdrawn before it could be granted");
    resp_wait = 3;
    expectGrant(1'b1, 32'h100, 32'h0, 4'h0);
    expectResp(1'b1, 32'hDEAD_BEEF);
    fork
      applyStimulus(1'b1, 32'h100, 32'h0, 4'h0);
      begin
        idleCycles(2);
        d_req = 1'b1; d_addr = 32'h44; d_wdata = 32'h0; d_wstrb = 4'h0;
        idleCycles(1);
        d_req = 1'b0;
      end
    join
    idleCycles(2);

    $display("[TB] simultaneous fetch and store");
    resp_wait = 2;
    expectGrant(1'b0, 32'h80, 32'h1234_5678, 4'hF);
    expectGrant(1'b1, 32'h104, 32'h0, 4'h0);
    expectResp(1'b0, memModel(32'h80));
    expectResp(1'b1, memModel(32'h104));
    fork
      applyStimulus(1'b0, 32'h80, 32'h1234_5678, 4'hF);
      applyStimulus(1'b1, 32'h104, 32'h0, 4'h0);
    join
    idleCycles(2);

    $display("[TB] starvation limit");
    resp_wait = 1;
    for (int i = 0; i < 4; i++) begin
      expectGrant(1'b0, 32'h400 + 32'(i * 4), 32'(i), 4'h0);
      expectResp(1'b0, memModel(32'h400 + 32'(i * 4)));
    end
    expectGrant(1'b1, 32'h180, 32'h0, 4'h0);
    expectResp(1'b1, memModel(32'h180));
    expectGrant(1'b0, 32'h410, 32'd4, 4'h0);
    expectResp(1'b0, memModel(32'h410));
    fork
      applyStimulus(1'b1, 32'h180, 32'h0, 4'h0);
      for (int j = 0; j < 5; j++) applyStimulus(1'b0, 32'h400 + 32'(j * 4), 32'(j), 4'h0);
    join
    idleCycles(2);

    $display("[TB] killed fetch, then a normal fetch");
    resp_wait = 3;
    expectGrant(1'b1, 32'h200, 32'h0, 4'h0);
    f_req = 1'b1; f_addr = 32'h200;
    idleCycles(1);
    f_kill = 1'b1; f_req = 1'b0;
    idleCycles(1);
    f_kill = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    checkOutput("kill_back_to_idle", busy, 0);
    idleCycles(1);
    expectGrant(1'b1, 32'h300, 32'h0, 4'h0);
    expectResp(1'b1, memModel(32'h300));
    applyStimulus(1'b1, 32'h300, 32'h0, 4'h0);
    idleCycles(2);

    $display("[TB] reset during a data transfer, coinciding with ext_ready");
    resp_wait = 3;
    expectGrant(1'b0, 32'h90, 32'hCAFE_F00D, 4'h3);
    d_req = 1'b1; d_addr = 32'h90; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'h3;
    idleCycles(3);
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checkOutput("reset_blocks_d_ready", d_ready, 0);
    idleCycles(1);
    checkOutput("reset_ext_valid", bus_if.ext_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ext_address", bus_if.ext_address, 0);
    checkOutput("reset_ext_write_strobe", bus_if.ext_write_strobe, 0);
    reset = 1'b1;
    idleCycles(2);

    $display("[TB] ext_ready held high, alternating fetch and data");
    hold_ready = 1'b1;
    vc_start = valid_cycles;
    expectGrant(1'b1, 32'h500, 32'h0, 4'h0);
    expectResp(1'b1, memModel(32'h500));
    expectGrant(1'b0, 32'h600, 32'hA5A5_0001, 4'h5);
    expectResp(1'b0, memModel(32'h600));
    expectGrant(1'b1, 32'h504, 32'h0, 4'h0);
    expectResp(1'b1, memModel(32'h504));
    expectGrant(1'b0, 32'h604, 32'h0, 4'h0);
    expectResp(1'b0, memModel(32'h604));
    applyStimulus(1'b1, 32'h500, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h600, 32'hA5A5_0001, 4'h5);
    applyStimulus(1'b1, 32'h504, 32'h0, 4'h0);
    applyStimulus(1'b0, 32'h604, 32'h0, 4'h0);
    idleCycles(2);
    checkOutput("valid_cycles_ready_held", valid_cycles - vc_start, 4);
    hold_ready = 1'b0;
    idleCycles(2);

    checkOutput("grant_q_drained", grant_q.size(), 0);
    checkOutput("resp_q_drained", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
